// File: rtl/rsa_pe_pkg.sv
// rtl/rsa_pe_pkg.sv - direction encodings, PE_mode bit indices and saturation helper for the RSA PE
package rsa_pe_pkg;

  localparam logic W_2_E = 1'b0;
  localparam logic E_2_W = 1'b1;
  localparam logic N_2_S = 1'b0;
  localparam logic S_2_N = 1'b1;

  localparam int MODE_H_BIT = 0;
  localparam int MODE_V_BIT = 1;

  // Wide enough for a sign-extended 2*RSA_DW product or accumulator sum
  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                  input int width);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    min_v = ~max_v;
    if (x > max_v) return max_v;
    else if (x < min_v) return min_v;
    else return x;
  endfunction

endpackage

// File: rtl/pe_qmul.sv
// rtl/pe_qmul.sv - stage 1: signed fixed-point multiply, shift, saturate to accumulator width
// PE_ROUND_EN selects round-half-up before the shift; default build truncates toward -inf.
module pe_qmul
  import rsa_pe_pkg::*;
#(
  parameter int RSA_DW   = 32,
  parameter int FRAC_BIT = 19,
  parameter int ACC_W    = 40
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_last,
  input  logic [RSA_DW-1:0] i_h,
  input  logic [RSA_DW-1:0] i_v,
  output logic [ACC_W-1:0]  o_prod,
  output logic              o_val,
  output logic              o_last,
  output logic              o_ovf
);

  localparam int PW = 2 * RSA_DW;

  logic signed [PW-1:0]    w_h_ext;
  logic signed [PW-1:0]    w_v_ext;
  logic signed [PW-1:0]    w_full;
  logic signed [PW-1:0]    w_rnd;
  logic signed [PW-1:0]    w_shift;
  logic signed [SAT_W-1:0] w_ext;
  logic signed [SAT_W-1:0] w_sat;
  logic                    w_clip;

  always_comb begin
    w_h_ext = {{RSA_DW{i_h[RSA_DW-1]}}, i_h};
    w_v_ext = {{RSA_DW{i_v[RSA_DW-1]}}, i_v};
    w_full  = w_h_ext * w_v_ext;
`ifdef PE_ROUND_EN
    w_rnd   = w_full + (PW'(1) << (FRAC_BIT - 1));
`else
    w_rnd   = w_full;
`endif
    w_shift = w_rnd >>> FRAC_BIT;
    w_ext   = {{(SAT_W-PW){w_shift[PW-1]}}, w_shift};
    w_sat   = sat(w_ext, ACC_W);
    w_clip  = (w_sat != w_ext);
  end

  always_ff @(posedge clk) begin
    if (sys_rst || i_clr || !i_en) begin
      o_prod <= '0;
      o_val  <= 1'b0;
      o_last <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      o_prod <= w_sat[ACC_W-1:0];
      o_val  <= 1'b1;
      o_last <= i_last;
      o_ovf  <= w_clip;
    end
  end

endmodule

// File: rtl/pe_mac_bidir.sv
// rtl/pe_mac_bidir.sv - bidirectional systolic PE: operand forwarding, 2-stage saturating MAC, result chain
// Optional round-half-up quantisation is enabled by defining PE_ROUND_EN.
module pe_mac_bidir
  import rsa_pe_pkg::*;
#(
  parameter int RSA_DW    = 32,
  parameter int FRAC_BIT  = 19,
  parameter int ACC_GUARD = 8
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [1:0]        PE_mode,
  input  logic              cal_en_N_i,
  input  logic              cal_en_S_i,
  output logic              cal_en_N_o,
  output logic              cal_en_S_o,
  input  logic              cal_done_N_i,
  input  logic              cal_done_S_i,
  output logic              cal_done_N_o,
  output logic              cal_done_S_o,
  input  logic [RSA_DW-1:0] v_data_N_i,
  input  logic [RSA_DW-1:0] v_data_S_i,
  output logic [RSA_DW-1:0] v_data_N_o,
  output logic [RSA_DW-1:0] v_data_S_o,
  input  logic [RSA_DW-1:0] h_data_W_i,
  input  logic [RSA_DW-1:0] h_data_E_i,
  output logic [RSA_DW-1:0] h_data_W_o,
  output logic [RSA_DW-1:0] h_data_E_o,
  input  logic              mulres_val_W_i,
  input  logic              mulres_val_E_i,
  input  logic [RSA_DW-1:0] mulres_W_i,
  input  logic [RSA_DW-1:0] mulres_E_i,
  output logic              mulres_val_W_o,
  output logic              mulres_val_E_o,
  output logic [RSA_DW-1:0] mulres_W_o,
  output logic [RSA_DW-1:0] mulres_E_o,
  output logic              ovf_o,
  output logic              coll_err_o
);

  localparam int ACC_W = RSA_DW + ACC_GUARD;

  logic [1:0]        r_mode;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf_st;
  logic              r_hold_v;
  logic [RSA_DW-1:0] r_hold_d;

  logic              w_mode_chg, w_v_s2n, w_v_n2s, w_h_e2w, w_h_w2e;
  logic              w_cal_en, w_cal_done, w_fwd_val;
  logic [RSA_DW-1:0] w_v_data, w_h_data, w_fwd_data;
  logic [ACC_W-1:0]  w_p_prod;
  logic              w_p_val, w_p_last, w_p_ovf;

  assign w_mode_chg = (PE_mode != r_mode);
  assign w_v_s2n    = (PE_mode[MODE_V_BIT] == S_2_N);
  assign w_v_n2s    = (PE_mode[MODE_V_BIT] == N_2_S);
  assign w_h_e2w    = (PE_mode[MODE_H_BIT] == E_2_W);
  assign w_h_w2e    = (PE_mode[MODE_H_BIT] == W_2_E);
  assign w_cal_en   = w_v_s2n ? cal_en_S_i   : cal_en_N_i;
  assign w_cal_done = w_v_s2n ? cal_done_S_i : cal_done_N_i;
  assign w_v_data   = w_v_s2n ? v_data_S_i   : v_data_N_i;
  assign w_h_data   = w_h_e2w ? h_data_E_i   : h_data_W_i;
  // Result chain runs against the horizontal operand flow
  assign w_fwd_val  = w_h_e2w ? mulres_val_W_i : mulres_val_E_i;
  assign w_fwd_data = w_h_e2w ? mulres_W_i     : mulres_E_i;

  pe_qmul #(
    .RSA_DW   (RSA_DW),
    .FRAC_BIT (FRAC_BIT),
    .ACC_W    (ACC_W)
  ) u_qmul (
    .clk     (clk),
    .sys_rst (sys_rst),
    .i_clr   (w_mode_chg),
    .i_en    (w_cal_en),
    .i_last  (w_cal_done),
    .i_h     (w_h_data),
    .i_v     (w_v_data),
    .o_prod  (w_p_prod),
    .o_val   (w_p_val),
    .o_last  (w_p_last),
    .o_ovf   (w_p_ovf)
  );

  logic signed [SAT_W-1:0] w_sum, w_acc_next, w_res;
  logic                    w_acc_clip, w_res_clip, w_local, w_hold_eff;
  logic                    w_out_val, w_hold_v_nx, w_drop;
  logic [RSA_DW-1:0]       w_out_data, w_hold_d_nx;

  always_comb begin
    w_sum      = {{(SAT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc}
               + {{(SAT_W-ACC_W){w_p_prod[ACC_W-1]}}, w_p_prod};
    w_acc_next = sat(w_sum, ACC_W);
    w_acc_clip = (w_acc_next != w_sum);
    w_res      = sat(w_sum, RSA_DW);
    w_res_clip = (w_res != w_sum);
  end

  // Chain arbitration: local result, then held value, then fresh forwarded input
  always_comb begin
    w_local     = w_p_last & ~w_mode_chg;
    w_hold_eff  = r_hold_v & ~w_mode_chg;
    w_out_val   = 1'b0;
    w_out_data  = '0;
    w_hold_v_nx = w_hold_eff;
    w_hold_d_nx = w_mode_chg ? '0 : r_hold_d;
    w_drop      = 1'b0;
    if (w_local) begin
      w_out_val  = 1'b1;
      w_out_data = w_res[RSA_DW-1:0];
      if (w_fwd_val) begin
        if (w_hold_eff) begin
          w_drop = 1'b1;
        end else begin
          w_hold_v_nx = 1'b1;
          w_hold_d_nx = w_fwd_data;
        end
      end
    end else if (w_hold_eff) begin
      w_out_val   = 1'b1;
      w_out_data  = r_hold_d;
      w_hold_v_nx = w_fwd_val;
      w_hold_d_nx = w_fwd_val ? w_fwd_data : r_hold_d;
    end else if (w_fwd_val) begin
      w_out_val  = 1'b1;
      w_out_data = w_fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cal_en_N_o   <= 1'b0;
      cal_en_S_o   <= 1'b0;
      cal_done_N_o <= 1'b0;
      cal_done_S_o <= 1'b0;
      v_data_N_o   <= '0;
      v_data_S_o   <= '0;
      h_data_W_o   <= '0;
      h_data_E_o   <= '0;
    end else begin
      cal_en_N_o   <= w_v_s2n & w_cal_en;
      cal_en_S_o   <= w_v_n2s & w_cal_en;
      cal_done_N_o <= w_v_s2n & w_cal_done;
      cal_done_S_o <= w_v_n2s & w_cal_done;
      v_data_N_o   <= (w_v_s2n && w_cal_en) ? w_v_data : '0;
      v_data_S_o   <= (w_v_n2s && w_cal_en) ? w_v_data : '0;
      h_data_W_o   <= (w_h_e2w && w_cal_en) ? w_h_data : '0;
      h_data_E_o   <= (w_h_w2e && w_cal_en) ? w_h_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_mode         <= '0;
      r_acc          <= '0;
      r_ovf_st       <= 1'b0;
      r_hold_v       <= 1'b0;
      r_hold_d       <= '0;
      mulres_val_W_o <= 1'b0;
      mulres_val_E_o <= 1'b0;
      mulres_W_o     <= '0;
      mulres_E_o     <= '0;
      ovf_o          <= 1'b0;
      coll_err_o     <= 1'b0;
    end else begin
      r_mode         <= PE_mode;
      r_hold_v       <= w_hold_v_nx;
      r_hold_d       <= w_hold_d_nx;
      mulres_val_W_o <= w_h_w2e & w_out_val;
      mulres_val_E_o <= w_h_e2w & w_out_val;
      mulres_W_o     <= w_h_w2e ? w_out_data : '0;
      mulres_E_o     <= w_h_e2w ? w_out_data : '0;
      ovf_o          <= w_local & (r_ovf_st | w_p_ovf | w_res_clip);
      if (w_drop) coll_err_o <= 1'b1;
      if (w_mode_chg || w_p_last) begin
        r_acc    <= '0;
        r_ovf_st <= 1'b0;
      end else if (w_p_val) begin
        r_acc    <= w_acc_next[ACC_W-1:0];
        r_ovf_st <= r_ovf_st | w_p_ovf | w_acc_clip;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_bidir.sv
// tb/tb_pe_mac_bidir.sv - directed self-checking bench for pe_mac_bidir
module tb_pe_mac_bidir;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic [1:0]    PE_mode;
  logic          cal_en_N_i, cal_en_S_i, cal_en_N_o, cal_en_S_o;
  logic          cal_done_N_i, cal_done_S_i, cal_done_N_o, cal_done_S_o;
  logic [DW-1:0] v_data_N_i, v_data_S_i, v_data_N_o, v_data_S_o;
  logic [DW-1:0] h_data_W_i, h_data_E_i, h_data_W_o, h_data_E_o;
  logic          mulres_val_W_i, mulres_val_E_i, mulres_val_W_o, mulres_val_E_o;
  logic [DW-1:0] mulres_W_i, mulres_E_i, mulres_W_o, mulres_E_o;
  logic          ovf_o, coll_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_mac_bidir #(.RSA_DW(32), .FRAC_BIT(19), .ACC_GUARD(8)) dut (
    .clk(clk), .sys_rst(sys_rst), .PE_mode(PE_mode),
    .cal_en_N_i(cal_en_N_i), .cal_en_S_i(cal_en_S_i),
    .cal_en_N_o(cal_en_N_o), .cal_en_S_o(cal_en_S_o),
    .cal_done_N_i(cal_done_N_i), .cal_done_S_i(cal_done_S_i),
    .cal_done_N_o(cal_done_N_o), .cal_done_S_o(cal_done_S_o),
    .v_data_N_i(v_data_N_i), .v_data_S_i(v_data_S_i),
    .v_data_N_o(v_data_N_o), .v_data_S_o(v_data_S_o),
    .h_data_W_i(h_data_W_i), .h_data_E_i(h_data_E_i),
    .h_data_W_o(h_data_W_o), .h_data_E_o(h_data_E_o),
    .mulres_val_W_i(mulres_val_W_i), .mulres_val_E_i(mulres_val_E_i),
    .mulres_W_i(mulres_W_i), .mulres_E_i(mulres_E_i),
    .mulres_val_W_o(mulres_val_W_o), .mulres_val_E_o(mulres_val_E_o),
    .mulres_W_o(mulres_W_o), .mulres_E_o(mulres_E_o),
    .ovf_o(ovf_o), .coll_err_o(coll_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an operand on the source side selected by the current PE_mode
  task automatic op(input logic en, input logic done, input logic [DW-1:0] h, input logic [DW-1:0] v);
    cal_en_N_i   = en & ~PE_mode[1];
    cal_en_S_i   = en & PE_mode[1];
    cal_done_N_i = done & ~PE_mode[1];
    cal_done_S_i = done & PE_mode[1];
    v_data_N_i   = PE_mode[1] ? '0 : v;
    v_data_S_i   = PE_mode[1] ? v : '0;
    h_data_W_i   = PE_mode[0] ? '0 : h;
    h_data_E_i   = PE_mode[0] ? h : '0;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, '0, '0);
    mulres_val_W_i = 1'b0;
    mulres_val_E_i = 1'b0;
    mulres_W_i     = '0;
    mulres_E_i     = '0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    PE_mode = 2'b00;
    idle();
    tick();
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_val_E_o, ovf_o, coll_err_o, cal_en_N_o, cal_en_S_o, cal_done_N_o, cal_done_S_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {mulres_val_W_o, mulres_val_E_o, ovf_o, coll_err_o, cal_en_N_o, cal_en_S_o, cal_done_N_o, cal_done_S_o});
    end
    n_checks++;
    if ((mulres_W_o | mulres_E_o | v_data_N_o | v_data_S_o | h_data_W_o | h_data_E_o) !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got nonzero OR %h expected 00000000",
               mulres_W_o | mulres_E_o | v_data_N_o | v_data_S_o | h_data_W_o | h_data_E_o);
    end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    op(1'b1, 1'b0, 32'h00080000, 32'h00080000);
    tick();
    n_checks++;
    if ({cal_en_S_o, v_data_S_o, h_data_E_o} !== {1'b1, 32'h00080000, 32'h00080000}) begin
      n_fail++;
      $display("FAIL basic_fwd: got en=%b v=%h h=%h expected en=1 v=00080000 h=00080000", cal_en_S_o, v_data_S_o, h_data_E_o);
    end
    n_checks++;
    if ({cal_en_N_o, v_data_N_o, h_data_W_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL basic_unused_side: got en=%b v=%h h=%h expected zeros", cal_en_N_o, v_data_N_o, h_data_W_o);
    end
    op(1'b1, 1'b0, 32'h00100000, 32'h00080000);
    tick();
    op(1'b1, 1'b1, 32'h00180000, 32'h00080000);
    tick();
    n_checks++;
    if ({mulres_val_W_o, cal_done_S_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_latency: got val=%b done_fwd=%b expected val=0 done_fwd=1", mulres_val_W_o, cal_done_S_o);
    end
    op(1'b0, 1'b0, 32'h0000DEAD, 32'h0000BEEF);
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o, ovf_o, mulres_val_E_o} !== {1'b1, 32'h00300000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got val=%b res=%h ovf=%b valE=%b expected val=1 res=00300000 ovf=0 valE=0",
               mulres_val_W_o, mulres_W_o, ovf_o, mulres_val_E_o);
    end
    n_checks++;
    if (h_data_E_o !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_gated_fwd: got %h expected 00000000", h_data_E_o);
    end
    idle();
    tick();
    n_checks++;
    if (mulres_val_W_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_single_pulse: got %b expected 0", mulres_val_W_o);
    end
  endtask

  task automatic test_saturation();
    op(1'b1, 1'b1, 32'h3E800000, 32'h3E800000);
    tick();
    idle();
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o, ovf_o} !== {1'b1, 32'h7FFFFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_pos: got val=%b res=%h ovf=%b expected val=1 res=7fffffff ovf=1", mulres_val_W_o, mulres_W_o, ovf_o);
    end
    op(1'b1, 1'b1, 32'hC1800000, 32'h3E800000);
    tick();
    idle();
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o, ovf_o} !== {1'b1, 32'h80000000, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_neg: got val=%b res=%h ovf=%b expected val=1 res=80000000 ovf=1", mulres_val_W_o, mulres_W_o, ovf_o);
    end
    tick();
    n_checks++;
    if (ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_ovf_pulse: got %b expected 0", ovf_o);
    end
  endtask

  task automatic test_rounding();
    logic [DW-1:0] exp_pos;
    logic [DW-1:0] exp_neg;
`ifdef PE_ROUND_EN
    exp_pos = 32'h00000001;
    exp_neg = 32'h00000000;
`else
    exp_pos = 32'h00000000;
    exp_neg = 32'hFFFFFFFF;
`endif
    op(1'b1, 1'b1, 32'h00000001, 32'h00040000);
    tick();
    idle();
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o, ovf_o} !== {1'b1, exp_pos, 1'b0}) begin
      n_fail++;
      $display("FAIL round_pos: got val=%b res=%h ovf=%b expected val=1 res=%h ovf=0", mulres_val_W_o, mulres_W_o, ovf_o, exp_pos);
    end
    op(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00040000);
    tick();
    idle();
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o} !== {1'b1, exp_neg}) begin
      n_fail++;
      $display("FAIL round_neg: got val=%b res=%h expected val=1 res=%h", mulres_val_W_o, mulres_W_o, exp_neg);
    end
  endtask

  task automatic test_mode11();
    PE_mode = 2'b11;
    idle();
    tick();
    tick();
    op(1'b1, 1'b0, 32'h00080000, 32'h00080000);
    tick();
    n_checks++;
    if ({cal_en_N_o, v_data_N_o, h_data_W_o} !== {1'b1, 32'h00080000, 32'h00080000}) begin
      n_fail++;
      $display("FAIL m11_fwd: got en=%b v=%h h=%h expected en=1 v=00080000 h=00080000", cal_en_N_o, v_data_N_o, h_data_W_o);
    end
    n_checks++;
    if ({cal_en_S_o, v_data_S_o, h_data_E_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL m11_unused_side: got en=%b v=%h h=%h expected zeros", cal_en_S_o, v_data_S_o, h_data_E_o);
    end
    op(1'b1, 1'b0, 32'h00100000, 32'h00080000);
    tick();
    op(1'b1, 1'b1, 32'h00180000, 32'h00080000);
    tick();
    idle();
    tick();
    n_checks++;
    if ({mulres_val_E_o, mulres_E_o, mulres_val_W_o, mulres_W_o} !== {1'b1, 32'h00300000, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL m11_result: got valE=%b resE=%h valW=%b resW=%h expected valE=1 resE=00300000 valW=0 resW=0",
               mulres_val_E_o, mulres_E_o, mulres_val_W_o, mulres_W_o);
    end
  endtask

  task automatic test_mode_change();
    PE_mode = 2'b00;
    idle();
    tick();
    tick();
    op(1'b1, 1'b0, 32'h00080000, 32'h00080000);
    tick();
    op(1'b1, 1'b0, 32'h00100000, 32'h00080000);
    tick();
    PE_mode = 2'b01;
    idle();
    tick();
    op(1'b1, 1'b1, 32'h00180000, 32'h00080000);
    tick();
    idle();
    tick();
    n_checks++;
    if ({mulres_val_E_o, mulres_E_o, mulres_val_W_o} !== {1'b1, 32'h00180000, 1'b0}) begin
      n_fail++;
      $display("FAIL modechg_result: got valE=%b resE=%h valW=%b expected valE=1 resE=00180000 valW=0",
               mulres_val_E_o, mulres_E_o, mulres_val_W_o);
    end
    PE_mode = 2'b00;
    op(1'b1, 1'b1, 32'h00280000, 32'h00080000);
    tick();
    n_checks++;
    if ({cal_en_S_o, h_data_E_o} !== {1'b1, 32'h00280000}) begin
      n_fail++;
      $display("FAIL modechg_fwd: got en=%b h=%h expected en=1 h=00280000", cal_en_S_o, h_data_E_o);
    end
    idle();
    tick();
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_val_E_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL modechg_done_ignored: got valW=%b valE=%b expected 00", mulres_val_W_o, mulres_val_E_o);
    end
  endtask

  task automatic test_collision();
    idle();
    mulres_val_E_i = 1'b1;
    mulres_E_i     = 32'h55AA55AA;
    tick();
    mulres_val_E_i = 1'b0;
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o} !== {1'b1, 32'h55AA55AA}) begin
      n_fail++;
      $display("FAIL chain_pass: got val=%b res=%h expected val=1 res=55aa55aa", mulres_val_W_o, mulres_W_o);
    end
    op(1'b1, 1'b1, 32'h00080000, 32'h00080000);
    tick();
    idle();
    mulres_val_E_i = 1'b1;
    mulres_E_i     = 32'h12345678;
    tick();
    mulres_val_E_i = 1'b0;
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o} !== {1'b1, 32'h00080000}) begin
      n_fail++;
      $display("FAIL coll_local_first: got val=%b res=%h expected val=1 res=00080000", mulres_val_W_o, mulres_W_o);
    end
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o, coll_err_o} !== {1'b1, 32'h12345678, 1'b0}) begin
      n_fail++;
      $display("FAIL coll_held: got val=%b res=%h err=%b expected val=1 res=12345678 err=0", mulres_val_W_o, mulres_W_o, coll_err_o);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    tick();
    op(1'b1, 1'b1, 32'h00080000, 32'h00080000);
    tick();
    op(1'b1, 1'b1, 32'h00100000, 32'h00080000);
    mulres_val_E_i = 1'b1;
    mulres_E_i     = 32'hAAAA0001;
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o} !== {1'b1, 32'h00080000}) begin
      n_fail++;
      $display("FAIL b2b_first: got val=%b res=%h expected val=1 res=00080000", mulres_val_W_o, mulres_W_o);
    end
    idle();
    mulres_val_E_i = 1'b1;
    mulres_E_i     = 32'hBBBB0002;
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o, coll_err_o} !== {1'b1, 32'h00100000, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_drop: got val=%b res=%h err=%b expected val=1 res=00100000 err=1", mulres_val_W_o, mulres_W_o, coll_err_o);
    end
    mulres_E_i = 32'hCCCC0003;
    tick();
    mulres_val_E_i = 1'b0;
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o} !== {1'b1, 32'hAAAA0001}) begin
      n_fail++;
      $display("FAIL b2b_hold_prio: got val=%b res=%h expected val=1 res=aaaa0001", mulres_val_W_o, mulres_W_o);
    end
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o} !== {1'b1, 32'hCCCC0003}) begin
      n_fail++;
      $display("FAIL b2b_refill: got val=%b res=%h expected val=1 res=cccc0003", mulres_val_W_o, mulres_W_o);
    end
    tick();
    n_checks++;
    if ({mulres_val_W_o, coll_err_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_sticky: got val=%b err=%b expected val=0 err=1", mulres_val_W_o, coll_err_o);
    end
  endtask

  task automatic test_reset_mid();
    op(1'b1, 1'b0, 32'h00100000, 32'h00080000);
    tick();
    op(1'b1, 1'b0, 32'h00100000, 32'h00080000);
    tick();
    sys_rst = 1'b1;
    idle();
    tick();
    n_checks++;
    if ({mulres_val_W_o, coll_err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got val=%b err=%b expected 00", mulres_val_W_o, coll_err_o);
    end
    sys_rst = 1'b0;
    tick();
    op(1'b1, 1'b1, 32'h00080000, 32'h00080000);
    tick();
    idle();
    tick();
    n_checks++;
    if ({mulres_val_W_o, mulres_W_o} !== {1'b1, 32'h00080000}) begin
      n_fail++;
      $display("FAIL rst_mid_result: got val=%b res=%h expected val=1 res=00080000", mulres_val_W_o, mulres_W_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_mode11();
    test_mode_change();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
